// File: rtl/vissplit_pkg.sv
// Correlator constants shared by the split and merge ends of the visibility chain,
// so both sides agree on the frame geometry.
package vissplit_pkg;
  localparam int CORR_LENGTH = 3;
  localparam int CORR_WIDTH  = 7;
endpackage

// File: rtl/vissplit.sv
// Serial-to-parallel visibility splitter: collects LENGTH daisy-chain items into a
// fill register and hands complete frames to a valid/ready hold register.
module vissplit
  import vissplit_pkg::*;
#(
  parameter int LENGTH  = CORR_LENGTH,
  parameter int WIDTH   = CORR_WIDTH,
  parameter bit REVERSE = 1'b1,
  localparam int CW     = $clog2(LENGTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    seq_valid_i,
  input  logic [WIDTH-1:0]        seq_rdata_i,
  input  logic [WIDTH-1:0]        seq_idata_i,
  output logic                    par_valid_o,
  input  logic                    par_ready_i,
  output logic [LENGTH*WIDTH-1:0] par_rdata_o,
  output logic [LENGTH*WIDTH-1:0] par_idata_o,
  output logic [CW-1:0]           fill_count_o,
  output logic                    overflow_o
);

  logic [CW-1:0]                  count_q, count_d;
  logic [LENGTH-1:0][WIDTH-1:0]   fill_r_q, fill_i_q;
  logic [LENGTH-1:0][WIDTH-1:0]   frame_r, frame_i;
  logic [LENGTH-1:0][WIDTH-1:0]   hold_r_q, hold_r_d, hold_i_q, hold_i_d;
  logic                           valid_q, valid_d;
  logic                           ovf_q, ovf_d;
  logic                           complete, xfer;
  int                             slot_idx;

  assign complete = seq_valid_i && (count_q == CW'(LENGTH - 1));
  assign xfer     = complete && (!valid_q || par_ready_i);

  // The fill contents with this cycle's item merged in; this is both the next fill
  // state and, on completion, the frame handed to the hold register.
  always_comb begin
    slot_idx = REVERSE ? int'(count_q) : (LENGTH - 1 - int'(count_q));
    frame_r  = fill_r_q;
    frame_i  = fill_i_q;
    for (int k = 0; k < LENGTH; k++) begin
      if (seq_valid_i && (k == slot_idx)) begin
        frame_r[k] = seq_rdata_i;
        frame_i[k] = seq_idata_i;
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    hold_r_d = hold_r_q;
    hold_i_d = hold_i_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    if (seq_valid_i) count_d = complete ? '0 : count_q + CW'(1);
    if (xfer) begin
      hold_r_d = frame_r;
      hold_i_d = frame_i;
      valid_d  = 1'b1;
    end else if (valid_q && par_ready_i) begin
      valid_d  = 1'b0;
    end
    // A completed frame with nowhere to go is dropped; the held frame stays put.
    if (complete && valid_q && !par_ready_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      hold_r_q <= '0;
      hold_i_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      hold_r_q <= hold_r_d;
      hold_i_q <= hold_i_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Slot storage needs no reset: the counter defines what is meaningful.
  always_ff @(posedge clock) begin
    if (seq_valid_i) begin
      fill_r_q <= frame_r;
      fill_i_q <= frame_i;
    end
  end

  assign par_valid_o  = valid_q;
  assign par_rdata_o  = hold_r_q;
  assign par_idata_o  = hold_i_q;
  assign fill_count_o = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_vissplit.sv
// Bench for vissplit: REVERSE=1 and REVERSE=0 instances share one input stream and
// are checked against a frame-level model built from item lists.
module tb_vissplit;
  localparam int L  = 3;
  localparam int W  = 7;
  localparam int CW = $clog2(L + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset = 1'b1;
  logic         v = 1'b0, rdy = 1'b0;
  logic [W-1:0] r = '0, i = '0;

  logic          va, vb, oa, ob;
  logic [L*W-1:0] ra, ia, rb, ib;
  logic [CW-1:0]  fa, fb;

  vissplit #(.LENGTH(L), .WIDTH(W), .REVERSE(1'b1)) dut_a (
    .clock(clock), .reset(reset), .seq_valid_i(v), .seq_rdata_i(r), .seq_idata_i(i),
    .par_valid_o(va), .par_ready_i(rdy), .par_rdata_o(ra), .par_idata_o(ia),
    .fill_count_o(fa), .overflow_o(oa));

  vissplit #(.LENGTH(L), .WIDTH(W), .REVERSE(1'b0)) dut_b (
    .clock(clock), .reset(reset), .seq_valid_i(v), .seq_rdata_i(r), .seq_idata_i(i),
    .par_valid_o(vb), .par_ready_i(rdy), .par_rdata_o(rb), .par_idata_o(ib),
    .fill_count_o(fb), .overflow_o(ob));

  int ncmp = 0, nfail = 0;

  // Model: items of the partial frame in arrival order, and the held frame in arrival order.
  int qr[$], qi[$];
  int fr_r[L], fr_i[L];
  bit mvalid = 1'b0, movf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arrival item j goes to slot j when REVERSE=1, slot L-1-j when REVERSE=0.
  function automatic logic [L*W-1:0] pack(input bit rev, input int arr[L]);
    logic [L*W-1:0] o;
    o = '0;
    for (int j = 0; j < L; j++) begin
      if (rev) o[j*W +: W] = W'(arr[j]);
      else     o[(L-1-j)*W +: W] = W'(arr[j]);
    end
    return o;
  endfunction

  task automatic step(input bit sv, input int sr, input int si, input bit srdy, input bit srst);
    bit ack, comp;
    v = sv; r = W'(sr); i = W'(si); rdy = srdy; reset = srst;
    @(posedge clock);
    if (srst) begin
      qr.delete(); qi.delete();
      mvalid = 1'b0; movf = 1'b0;
      for (int j = 0; j < L; j++) begin fr_r[j] = 0; fr_i[j] = 0; end
    end else begin
      ack  = mvalid && srdy;
      comp = sv && (qr.size() == L - 1);
      if (sv) begin qr.push_back(sr % (1 << W)); qi.push_back(si % (1 << W)); end
      if (comp) begin
        if (!mvalid || srdy) begin
          for (int j = 0; j < L; j++) begin fr_r[j] = qr[j]; fr_i[j] = qi[j]; end
          mvalid = 1'b1;
        end else begin
          movf = 1'b1;
        end
        qr.delete(); qi.delete();
      end else if (ack) begin
        mvalid = 1'b0;
      end
    end
    #1;
    chk("valid_a", 64'(va), 64'(mvalid));
    chk("valid_b", 64'(vb), 64'(mvalid));
    chk("rdata_a", 64'(ra), 64'(pack(1'b1, fr_r)));
    chk("idata_a", 64'(ia), 64'(pack(1'b1, fr_i)));
    chk("rdata_b", 64'(rb), 64'(pack(1'b0, fr_r)));
    chk("idata_b", 64'(ib), 64'(pack(1'b0, fr_i)));
    chk("fill_a", 64'(fa), 64'(qr.size()));
    chk("fill_b", 64'(fb), 64'(qr.size()));
    chk("ovf_a", 64'(oa), 64'(movf));
    chk("ovf_b", 64'(ob), 64'(movf));
  endtask

  initial begin
    // Reset with a stray strobe that must be ignored.
    step(1, 5, 5, 1, 1);
    step(0, 0, 0, 1, 1);

    // Basic frame, both orderings.
    step(1, 1, 11, 1, 0);
    step(1, 2, 12, 1, 0);
    step(1, 3, 13, 1, 0);
    chk("a_slot0_r", 64'(ra[0 +: W]), 64'd1);
    chk("a_slot0_i", 64'(ia[0 +: W]), 64'd11);
    chk("a_slot2_r", 64'(ra[2*W +: W]), 64'd3);
    chk("a_slot2_i", 64'(ia[2*W +: W]), 64'd13);
    chk("b_slot2_r", 64'(rb[2*W +: W]), 64'd1);
    chk("b_slot0_i", 64'(ib[0 +: W]), 64'd13);
    step(0, 0, 0, 1, 0);
    chk("drop_after_accept", 64'(va), 64'd0);

    // Stalled downstream: second frame is dropped.
    for (int k = 0; k < 6; k++) step(1, 10 + k, 20 + k, 0, 0);
    chk("stall_ovf", 64'(oa), 64'd1);
    chk("stall_fill", 64'(fa), 64'd0);
    chk("stall_hold_r", 64'(ra[0 +: W]), 64'd10);
    chk("stall_hold_i", 64'(ia[2*W +: W]), 64'd22);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("ovf_sticky", 64'(oa), 64'd1);
    step(0, 0, 0, 0, 1);

    // Continuous nine-item stream.
    for (int k = 0; k < 9; k++) step(1, 30 + k, 40 + k, 1, 0);
    chk("stream_no_ovf", 64'(oa), 64'd0);
    step(0, 0, 0, 1, 0);

    // Reset mid-frame.
    step(1, 50, 60, 1, 0);
    step(1, 51, 61, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("mid_rst_fill", 64'(fa), 64'd0);
    chk("mid_rst_valid", 64'(va), 64'd0);
    step(1, 21, 31, 1, 0);
    step(1, 22, 32, 1, 0);
    step(1, 23, 33, 1, 0);
    chk("fresh_slot0", 64'(ra[0 +: W]), 64'd21);

    // Gapped strobes.
    step(1, 7, 8, 1, 0);
    step(0, 99, 99, 1, 0);
    step(0, 98, 98, 1, 0);
    step(1, 9, 10, 1, 0);
    step(0, 97, 97, 1, 0);
    step(1, 11, 12, 1, 0);
    chk("gap_slot1", 64'(ra[W +: W]), 64'd9);

    // Randomized traffic.
    for (int k = 0; k < 500; k++)
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 127)), bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 99) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
